// File: rtl/conv_pkg.sv
// Shared constants for the conv1d datapath.
//   BW         : weight element width (signed)
//   BIAS_BW    : bias width (signed)
//   FILTER_LEN : kernel taps per filter (one weight bank per tap)
//   NUM_BANKS  : weight banks plus the bias bank
//   BANK_BW    : width of the manual-port bank selector
//   BANK_BIAS  : selector value that addresses the bias bank
package conv_pkg;
  localparam int BW         = 8;
  localparam int BIAS_BW    = 32;
  localparam int FILTER_LEN = 3;
  localparam int NUM_BANKS  = 4;
  localparam int BANK_BW    = 2;
  localparam logic [BANK_BW-1:0] BANK_BIAS = 2'd3;
endpackage

// File: rtl/conv_mem_bank.sv
// Register-file bank, DEPTH entries of W bits.
//   clk_i/rst_i           : clock, sync active-high reset (clears read regs only)
//   wr_en_i/addr/data     : sync write port
//   rd_en_i/rd_addr_i     : manual read; rd_data_o registered, holds when idle
//   st_en_i/st_addr_i     : stream read; st_data_o registered, holds when idle
// Contents are not reset. A read of an entry written on the same edge
// returns the old value.
module conv_mem_bank #(
  parameter  int W     = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o,
  input  logic          st_en_i,
  input  logic [AW-1:0] st_addr_i,
  output logic [W-1:0]  st_data_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_q, st_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q <= '0;
      st_q <= '0;
    end else begin
      if (rd_en_i) rd_q <= mem_q[rd_addr_i];
      if (st_en_i) st_q <= mem_q[st_addr_i];
    end
  end

  assign rd_data_o = rd_q;
  assign st_data_o = st_q;
endmodule

// File: rtl/conv_weight_mem.sv
// Weight/bias store for the conv1d layer. Streams {tap0,tap1,tap2,bias}
// for filters 0..NUM_FILTERS-1, once per frame position, one filter per
// advance (cycle_en_i & ready_i), with 1-cycle latency.
//   clk_i, rst_i                 : clock, sync active-high reset
//   cycle_en_i, ready_i          : stream advance qualifiers
//   rd_en_i, wr_en_i             : manual read / write strobes
//   rd_wr_bank_i, rd_wr_addr_i   : bank (0..2 taps, 3 bias) and filter index
//   wr_data_i / rd_data_o        : manual data; bias sign-extended on read
//   data0_o..data2_o, bias_o     : streamed parameters of the current filter
//   valid_o, last_o              : beat valid; final filter of final position
module conv_weight_mem
  import conv_pkg::*;
#(
  parameter  int BW          = conv_pkg::BW,
  parameter  int BIAS_BW     = conv_pkg::BIAS_BW,
  parameter  int FRAME_LEN   = 50,
  parameter  int COLUMN_LEN  = 13,
  parameter  int NUM_FILTERS = 8,
  localparam int VECTOR_BW   = COLUMN_LEN*BW,
  localparam int ADDR_BW     = $clog2(NUM_FILTERS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cycle_en_i,
  input  logic                 rd_en_i,
  input  logic                 wr_en_i,
  input  logic [BANK_BW-1:0]   rd_wr_bank_i,
  input  logic [ADDR_BW-1:0]   rd_wr_addr_i,
  input  logic [VECTOR_BW-1:0] wr_data_i,
  output logic [VECTOR_BW-1:0] rd_data_o,
  output logic [VECTOR_BW-1:0] data0_o,
  output logic [VECTOR_BW-1:0] data1_o,
  output logic [VECTOR_BW-1:0] data2_o,
  output logic [BIAS_BW-1:0]   bias_o,
  output logic                 valid_o,
  output logic                 last_o,
  input  logic                 ready_i
);
  localparam int FRAME_BW = $clog2(FRAME_LEN);
  localparam logic [ADDR_BW-1:0]  FILT_MAX  = ADDR_BW'(NUM_FILTERS-1);
  localparam logic [FRAME_BW-1:0] FRAME_MAX = FRAME_BW'(FRAME_LEN-1);

  logic [ADDR_BW-1:0]  filter_cnt_q, filter_cnt_d;
  logic [FRAME_BW-1:0] frame_cnt_q, frame_cnt_d;
  logic                adv, last_d;
  logic                valid_q, last_q;
  logic [BANK_BW-1:0]  rd_bank_q;

  logic [FILTER_LEN-1:0][VECTOR_BW-1:0] w_st, w_rd;
  logic [BIAS_BW-1:0]                   b_st, b_rd;

  assign adv = cycle_en_i & ready_i;

  // Stream address is the pre-increment filter count, so the beat
  // registered on this edge belongs to filter_cnt_q.
  for (genvar k = 0; k < FILTER_LEN; k++) begin : g_wbank
    conv_mem_bank #(.W(VECTOR_BW), .DEPTH(NUM_FILTERS)) u_bank (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (wr_en_i && (rd_wr_bank_i == BANK_BW'(k))),
      .wr_addr_i (rd_wr_addr_i),
      .wr_data_i (wr_data_i),
      .rd_en_i   (rd_en_i && (rd_wr_bank_i == BANK_BW'(k))),
      .rd_addr_i (rd_wr_addr_i),
      .rd_data_o (w_rd[k]),
      .st_en_i   (adv),
      .st_addr_i (filter_cnt_q),
      .st_data_o (w_st[k])
    );
  end

  conv_mem_bank #(.W(BIAS_BW), .DEPTH(NUM_FILTERS)) u_bias (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en_i && (rd_wr_bank_i == BANK_BIAS)),
    .wr_addr_i (rd_wr_addr_i),
    .wr_data_i (wr_data_i[BIAS_BW-1:0]),
    .rd_en_i   (rd_en_i && (rd_wr_bank_i == BANK_BIAS)),
    .rd_addr_i (rd_wr_addr_i),
    .rd_data_o (b_rd),
    .st_en_i   (adv),
    .st_addr_i (filter_cnt_q),
    .st_data_o (b_st)
  );

  always_comb begin
    filter_cnt_d = filter_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    last_d       = 1'b0;
    if (adv) begin
      if (filter_cnt_q == FILT_MAX) begin
        filter_cnt_d = '0;
        frame_cnt_d  = (frame_cnt_q == FRAME_MAX) ? '0 : frame_cnt_q + FRAME_BW'(1);
        last_d       = (frame_cnt_q == FRAME_MAX);
      end else begin
        filter_cnt_d = filter_cnt_q + ADDR_BW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filter_cnt_q <= '0;
      frame_cnt_q  <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      rd_bank_q    <= '0;
    end else begin
      filter_cnt_q <= filter_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      valid_q      <= adv;
      last_q       <= last_d;
      if (rd_en_i) rd_bank_q <= rd_wr_bank_i;
    end
  end

  // Each bank's read register holds, so steering by the last-read bank
  // keeps rd_data_o stable between reads.
  always_comb begin
    rd_data_o = '0;
    if (rd_bank_q == BANK_BIAS) rd_data_o = {{(VECTOR_BW-BIAS_BW){b_rd[BIAS_BW-1]}}, b_rd};
    else                        rd_data_o = w_rd[rd_bank_q];
  end

  assign data0_o = w_st[0];
  assign data1_o = w_st[1];
  assign data2_o = w_st[2];
  assign bias_o  = b_st;
  assign valid_o = valid_q;
  assign last_o  = last_q;
endmodule

// File: tb/tb_conv_weight_mem.sv
module tb_conv_weight_mem;
  localparam int NF   = 8;
  localparam int FL   = 50;
  localparam int VW   = 104;
  localparam int BBW  = 32;
  localparam int PASS = NF*FL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cycle_en, rd_en, wr_en, ready;
  logic [1:0]    bank;
  logic [2:0]    addr;
  logic [VW-1:0] wr_data, rd_data, d0, d1, d2;
  logic [BBW-1:0] bias;
  logic          valid, last;

  conv_weight_mem dut (
    .clk_i(clk), .rst_i(rst), .cycle_en_i(cycle_en), .rd_en_i(rd_en), .wr_en_i(wr_en),
    .rd_wr_bank_i(bank), .rd_wr_addr_i(addr), .wr_data_i(wr_data), .rd_data_o(rd_data),
    .data0_o(d0), .data1_o(d1), .data2_o(d2), .bias_o(bias), .valid_o(valid),
    .last_o(last), .ready_i(ready)
  );

  int checks = 0, failures = 0;
  int beat; // advances since the last reset
  logic [VW-1:0]  wm [3][NF];
  logic [BBW-1:0] bm [NF];
  logic [VW-1:0]  h0, h1, h2;
  logic [BBW-1:0] hb;

  typedef struct {
    logic [1:0]    bank;
    logic [2:0]    addr;
    logic [VW-1:0] exp;
  } rd_vec_t;
  rd_vec_t tbl [4*NF];

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s beat=%0d got=%h exp=%h", nm, beat, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[i*32 +: 32] = $urandom;
    return v[VW-1:0];
  endfunction

  function automatic logic [VW-1:0] exp_rd(input logic [1:0] b, input logic [2:0] a);
    if (b == 2'd3) return VW'($signed(bm[a]));
    return wm[b][a];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cycle_en = 0; rd_en = 0; wr_en = 0;
  endtask

  task automatic model_write(input logic [1:0] b, input logic [2:0] a, input logic [VW-1:0] d);
    if (b == 2'd3) bm[a] = d[BBW-1:0];
    else           wm[b][a] = d;
  endtask

  task automatic do_write(input logic [1:0] b, input logic [2:0] a, input logic [VW-1:0] d);
    idle(); wr_en = 1; bank = b; addr = a; wr_data = d;
    tick(); wr_en = 0;
    model_write(b, a, d);
  endtask

  task automatic do_read(input logic [1:0] b, input logic [2:0] a);
    idle(); rd_en = 1; bank = b; addr = a;
    tick(); rd_en = 0;
  endtask

  task automatic apply_reset();
    idle(); rst = 1; tick(); rst = 0;
    beat = 0; h0 = '0; h1 = '0; h2 = '0; hb = '0;
  endtask

  // One stream cycle, optionally with a manual write. Expected beat content is
  // snapshotted from the model before the write lands (same-edge write is old).
  task automatic step(input bit en, input bit rdy, input bit wr,
                      input logic [1:0] b, input logic [2:0] a, input logic [VW-1:0] d);
    int f;
    logic [VW-1:0] e0, e1, e2;
    logic [BBW-1:0] eb;
    bit el;
    f  = beat % NF;
    e0 = wm[0][f]; e1 = wm[1][f]; e2 = wm[2][f]; eb = bm[f];
    el = ((beat % PASS) == PASS-1);
    cycle_en = en; ready = rdy; rd_en = 0; wr_en = wr; bank = b; addr = a; wr_data = d;
    tick();
    wr_en = 0;
    if (wr) model_write(b, a, d);
    if (en && rdy) begin
      chk("st_valid", VW'(valid), VW'(1'b1));
      chk("st_data0", d0, e0);
      chk("st_data1", d1, e1);
      chk("st_data2", d2, e2);
      chk("st_bias",  VW'(bias), VW'(eb));
      chk("st_last",  VW'(last), VW'(el));
      h0 = e0; h1 = e1; h2 = e2; hb = eb;
      beat++;
    end else begin
      chk("idle_valid", VW'(valid), '0);
      chk("idle_last",  VW'(last), '0);
      chk("idle_hold0", d0, h0);
      chk("idle_holdb", VW'(bias), VW'(hb));
    end
  endtask

  initial begin
    logic [VW-1:0] neg_bias, old_v, new_v;
    rst = 1; ready = 0; bank = 0; addr = 0; wr_data = '0; idle();
    beat = 0;
    tick(); tick();
    apply_reset();

    // Reset state
    chk("rst_valid", VW'(valid), '0);
    chk("rst_last",  VW'(last), '0);
    chk("rst_data0", d0, '0);
    chk("rst_data1", d1, '0);
    chk("rst_data2", d2, '0);
    chk("rst_bias",  VW'(bias), '0);
    chk("rst_rd",    rd_data, '0);

    // Fill every bank/entry, then read back from a table
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < NF; a++) do_write(2'(b), 3'(a), rand_vec());
    for (int i = 0; i < 4*NF; i++) begin
      tbl[i].bank = 2'(i / NF);
      tbl[i].addr = 3'(i % NF);
      tbl[i].exp  = exp_rd(tbl[i].bank, tbl[i].addr);
    end
    for (int i = 0; i < 4*NF; i++) begin
      do_read(tbl[i].bank, tbl[i].addr);
      chk("rd_tbl", rd_data, tbl[i].exp);
    end
    idle(); tick();
    chk("rd_hold", rd_data, tbl[4*NF-1].exp);

    // Negative bias sign extension
    do_write(2'd3, 3'd5, VW'(32'h8000_0001));
    do_read(2'd3, 3'd5);
    neg_bias = {{72{1'b1}}, 32'h8000_0001};
    chk("bias_sext", rd_data, neg_bias);

    // Continuous streaming for one pass plus one beat
    step(0, 1, 0, 0, 0, '0);
    for (int i = 0; i < PASS+1; i++) step(1, 1, 0, 0, 0, '0);

    // 1010 enable pattern with ready dropped for 3 cycles
    for (int i = 0; i < 12; i++) step(i % 2 == 0, !(i >= 4 && i < 7), 0, 0, 0, '0);

    // Same-cycle read and write to bank1 addr2
    old_v = wm[1][2];
    new_v = ~old_v;
    idle(); rd_en = 1; wr_en = 1; bank = 2'd1; addr = 3'd2; wr_data = new_v;
    tick(); idle();
    model_write(2'd1, 3'd2, new_v);
    chk("rw_old", rd_data, old_v);
    do_read(2'd1, 3'd2);
    chk("rw_new", rd_data, new_v);

    // Randomised streaming with occasional writes
    for (int i = 0; i < 300; i++)
      step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 8) == 0,
           2'($urandom), 3'($urandom), rand_vec());

    // Reset mid-pass at beat 123
    apply_reset();
    for (int i = 0; i < 123; i++) step(1, 1, 0, 0, 0, '0);
    cycle_en = 1; ready = 1; rst = 1;
    tick();
    rst = 0; idle();
    beat = 0; h0 = '0; h1 = '0; h2 = '0; hb = '0;
    chk("mid_rst_valid", VW'(valid), '0);
    chk("mid_rst_last",  VW'(last), '0);
    chk("mid_rst_data0", d0, '0);
    chk("mid_rst_bias",  VW'(bias), '0);
    step(1, 1, 0, 0, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
